// File: rtl/cycloneiiigl_fb_phase_det_if.sv
// ---------------------------------------------------------------------------
// cycloneiiigl_fb_phase_det_if
// Signal bundle between the PLL feedback path and the sampled phase/frequency
// detector.
//   refclk, fbclk : clocks under comparison (asynchronous to the sampling clk)
//   up, dn        : correction requests while a leading edge is pending
//   phase_err     : magnitude of the last measured edge separation (clk cycles)
//   ref_leads     : sign of the last measurement (1 = reference edge first)
//   err_valid     : one-cycle strobe marking a new phase_err/ref_leads
//   slip          : one-cycle strobe, second leading edge before lagging edge
//   locked, loss  : lock indication and missing-edge indication
// modport slave  : detector side (consumes clocks, drives results)
// modport master : clock source / observer side
// ---------------------------------------------------------------------------
interface cycloneiiigl_fb_phase_det_if #(
    parameter int ERR_W = 16
);
    logic             refclk;
    logic             fbclk;
    logic             up;
    logic             dn;
    logic [ERR_W-1:0] phase_err;
    logic             ref_leads;
    logic             err_valid;
    logic             slip;
    logic             locked;
    logic             loss;

    modport slave (
        input  refclk, fbclk,
        output up, dn, phase_err, ref_leads, err_valid, slip, locked, loss
    );

    modport master (
        output refclk, fbclk,
        input  up, dn, phase_err, ref_leads, err_valid, slip, locked, loss
    );
endinterface

// File: rtl/cycloneiiigl_fb_phase_det.sv
// ---------------------------------------------------------------------------
// cycloneiiigl_fb_phase_det
// Sampled phase/frequency detector and lock monitor. refclk and fbclk are
// synchronised into clk, their rising edges are detected, and the separation
// between a leading edge and the matching lagging edge is counted in clk
// cycles. The detector drives up/dn correction requests, a signed phase-error
// measurement, slip/loss indications and a locked flag.
//
// Ports:
//   clk    : sampling clock
//   reset  : asynchronous, active-high reset
//   pfd    : cycloneiiigl_fb_phase_det_if.slave (refclk/fbclk in, results out)
//
// Parameters:
//   ERR_W    : width of phase_err and of the edge-separation counter
//   LOCK_TOL : largest |phase error| counted as a good comparison
//   LOCK_CNT : consecutive good comparisons needed for locked
//   TIMEOUT  : counter value that declares a missing edge (< 2**ERR_W)
//
// Build option:
//   CYCLONEIIIGL_PFD_STICKY_LOSS_EN : when defined, loss is set by a timeout
//   or a slip and held until reset, and locked is held low while loss is set.
//   When undefined, loss is a one-cycle timeout strobe.
// ---------------------------------------------------------------------------
module cycloneiiigl_fb_phase_det #(
    parameter int ERR_W    = 16,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic reset,
    cycloneiiigl_fb_phase_det_if.slave pfd
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [ERR_W-1:0]  ZERO_V = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]  ONE_V  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  TOL_V  = ERR_W'(LOCK_TOL);
    localparam logic [ERR_W-1:0]  TOUT_V = ERR_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GONE_V = GOOD_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2
    } state_t;

    // Synchroniser and edge-history registers
    logic ref_s1_r, ref_s2_r, ref_s3_r;
    logic fb_s1_r,  fb_s2_r,  fb_s3_r;
    logic ref_rise_s, fb_rise_s;

    // Measurement state and registered outputs
    state_t           state_r;
    logic [ERR_W-1:0] cnt_r;
    logic             up_r, dn_r;
    logic [ERR_W-1:0] phase_err_r;
    logic             ref_leads_r;
    logic             err_valid_r;
    logic             slip_r;
    logic             loss_r;

    // Lock monitor
    logic [GOOD_W-1:0] good_cnt_r;
    logic              locked_r;

    // Per-edge events decoded from the current state and detected rises
    logic             meas_s;
    logic [ERR_W-1:0] meas_err_s;
    logic             meas_lead_s;
    logic             slip_ev_s;
    logic             tout_s;
    logic             good_s;
    logic             bad_s;

    // Two-flop synchronisers plus one edge-history flop on both clocks so the
    // two paths have identical latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_s1_r <= 1'b0;
            ref_s2_r <= 1'b0;
            ref_s3_r <= 1'b0;
            fb_s1_r  <= 1'b0;
            fb_s2_r  <= 1'b0;
            fb_s3_r  <= 1'b0;
        end else begin
            ref_s1_r <= pfd.refclk;
            ref_s2_r <= ref_s1_r;
            ref_s3_r <= ref_s2_r;
            fb_s1_r  <= pfd.fbclk;
            fb_s2_r  <= fb_s1_r;
            fb_s3_r  <= fb_s2_r;
        end
    end

    assign ref_rise_s = ref_s2_r & ~ref_s3_r;
    assign fb_rise_s  = fb_s2_r  & ~fb_s3_r;

    // Decode what happens on this edge: measurement, slip or timeout.
    // A completing edge always wins over a new leading edge, which in turn
    // wins over the timeout check.
    always_comb begin
        meas_s      = 1'b0;
        meas_err_s  = ZERO_V;
        meas_lead_s = 1'b0;
        slip_ev_s   = 1'b0;
        tout_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ref_rise_s && fb_rise_s) begin
                    meas_s = 1'b1;
                end else begin
                    meas_s = 1'b0;
                end
            end
            WAIT_FB: begin
                if (fb_rise_s) begin
                    meas_s      = 1'b1;
                    meas_err_s  = cnt_r;
                    meas_lead_s = 1'b1;
                end else if (ref_rise_s) begin
                    slip_ev_s = 1'b1;
                end else if (cnt_r == TOUT_V) begin
                    tout_s = 1'b1;
                end else begin
                    tout_s = 1'b0;
                end
            end
            WAIT_REF: begin
                if (ref_rise_s) begin
                    meas_s     = 1'b1;
                    meas_err_s = cnt_r;
                end else if (fb_rise_s) begin
                    slip_ev_s = 1'b1;
                end else if (cnt_r == TOUT_V) begin
                    tout_s = 1'b1;
                end else begin
                    tout_s = 1'b0;
                end
            end
            default: begin
                meas_s = 1'b0;
            end
        endcase
    end

    assign good_s = meas_s & (meas_err_s <= TOL_V);
    assign bad_s  = meas_s & (meas_err_s >  TOL_V);

    // Measurement FSM: tracks the pending leading edge, counts the separation
    // and registers all detector outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= ZERO_V;
            up_r        <= 1'b0;
            dn_r        <= 1'b0;
            phase_err_r <= ZERO_V;
            ref_leads_r <= 1'b0;
            err_valid_r <= 1'b0;
            slip_r      <= 1'b0;
            loss_r      <= 1'b0;
        end else begin
            err_valid_r <= meas_s;
            slip_r      <= slip_ev_s;
            if (meas_s) begin
                phase_err_r <= meas_err_s;
                ref_leads_r <= meas_lead_s;
            end else begin
                phase_err_r <= phase_err_r;
                ref_leads_r <= ref_leads_r;
            end
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
            if (tout_s || slip_ev_s) begin
                loss_r <= 1'b1;
            end else begin
                loss_r <= loss_r;
            end
`else
            loss_r <= tout_s;
`endif
            case (state_r)
                IDLE: begin
                    if (ref_rise_s && fb_rise_s) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO_V;
                        up_r    <= 1'b0;
                        dn_r    <= 1'b0;
                    end else if (ref_rise_s) begin
                        state_r <= WAIT_FB;
                        cnt_r   <= ONE_V;
                        up_r    <= 1'b1;
                        dn_r    <= 1'b0;
                    end else if (fb_rise_s) begin
                        state_r <= WAIT_REF;
                        cnt_r   <= ONE_V;
                        up_r    <= 1'b0;
                        dn_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO_V;
                        up_r    <= 1'b0;
                        dn_r    <= 1'b0;
                    end
                end
                WAIT_FB: begin
                    dn_r <= 1'b0;
                    if (fb_rise_s) begin
                        // A simultaneous ref rise immediately opens the next lead.
                        if (ref_rise_s) begin
                            state_r <= WAIT_FB;
                            cnt_r   <= ONE_V;
                            up_r    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            cnt_r   <= ZERO_V;
                            up_r    <= 1'b0;
                        end
                    end else if (ref_rise_s) begin
                        state_r <= WAIT_FB;
                        cnt_r   <= ONE_V;
                        up_r    <= 1'b1;
                    end else if (tout_s) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO_V;
                        up_r    <= 1'b0;
                    end else begin
                        state_r <= WAIT_FB;
                        cnt_r   <= cnt_r + ONE_V;
                        up_r    <= 1'b1;
                    end
                end
                WAIT_REF: begin
                    up_r <= 1'b0;
                    if (ref_rise_s) begin
                        if (fb_rise_s) begin
                            state_r <= WAIT_REF;
                            cnt_r   <= ONE_V;
                            dn_r    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            cnt_r   <= ZERO_V;
                            dn_r    <= 1'b0;
                        end
                    end else if (fb_rise_s) begin
                        state_r <= WAIT_REF;
                        cnt_r   <= ONE_V;
                        dn_r    <= 1'b1;
                    end else if (tout_s) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO_V;
                        dn_r    <= 1'b0;
                    end else begin
                        state_r <= WAIT_REF;
                        cnt_r   <= cnt_r + ONE_V;
                        dn_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= ZERO_V;
                    up_r    <= 1'b0;
                    dn_r    <= 1'b0;
                end
            endcase
        end
    end

    // Lock monitor: counts consecutive good measurements; locked rises on the
    // edge after the count saturates and drops on any bad event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt_r <= {GOOD_W{1'b0}};
            locked_r   <= 1'b0;
        end else if (bad_s || slip_ev_s || tout_s) begin
            good_cnt_r <= {GOOD_W{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            if (good_s && (good_cnt_r != LOCK_V)) begin
                good_cnt_r <= good_cnt_r + GONE_V;
            end else begin
                good_cnt_r <= good_cnt_r;
            end
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
            if (loss_r) begin
                locked_r <= 1'b0;
            end else if (good_cnt_r == LOCK_V) begin
                locked_r <= 1'b1;
            end else begin
                locked_r <= locked_r;
            end
`else
            if (good_cnt_r == LOCK_V) begin
                locked_r <= 1'b1;
            end else begin
                locked_r <= locked_r;
            end
`endif
        end
    end

    assign pfd.up        = up_r;
    assign pfd.dn        = dn_r;
    assign pfd.phase_err = phase_err_r;
    assign pfd.ref_leads = ref_leads_r;
    assign pfd.err_valid = err_valid_r;
    assign pfd.slip      = slip_r;
    assign pfd.locked    = locked_r;
    assign pfd.loss      = loss_r;

endmodule

// File: tb/tb_cycloneiiigl_fb_phase_det.sv
// ---------------------------------------------------------------------------
// tb_cycloneiiigl_fb_phase_det
// Directed bench for the sampled phase detector. Clock waveforms are built
// per cycle from (enable, start, period) settings. A timestamp model tracks
// the pending leading edge and lock history and predicts every output on
// every cycle; hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_cycloneiiigl_fb_phase_det;

    localparam int ERR_W = 16;
    localparam int TOL   = 2;
    localparam int LCNT  = 8;
    localparam int TOUT  = 64;
    localparam int HN    = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cycloneiiigl_fb_phase_det_if #(.ERR_W(ERR_W)) pfd ();

    cycloneiiigl_fb_phase_det #(
        .ERR_W(ERR_W), .LOCK_TOL(TOL), .LOCK_CNT(LCNT), .TIMEOUT(TOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pfd  (pfd)
    );

    initial forever #5 clk = ~clk;

    // stimulus settings
    bit rst_req = 1'b1;
    bit ref_en = 1'b0, fb_en = 1'b0;
    int ref_t0 = 0, fb_t0 = 0, ref_per = 20, fb_per = 20;
    bit hist_ref [HN];
    bit hist_fb  [HN];
    int e = 0;

    int n_cmp = 0, n_fail = 0;

    // model state
    int pend = 0;       // 0 none, 1 ref leading, 2 fb leading
    int t_start = 0;
    int g = 0;
    int lock_edge = -1;
    int m_err = 0;
    bit m_up, m_dn, m_lead, m_ev, m_slip, m_lossp, loss_st;

    // tracking for literal checks
    int ev_n, edge8, up_run, dn_run, up_tot, dn_tot, up_first;
    int slip_n, loss_n, loss_first, lock_first, exp_run;
    bit locked_seen;

    function automatic bit lvl(bit en, int t0, int per, int n);
        if (!en || n < t0) return 1'b0;
        return ((n - t0) % per) < (per / 2);
    endfunction

    function void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp);
        end
    endfunction

    function void model_reset();
        pend = 0; t_start = 0; g = 0; lock_edge = -1; m_err = 0;
        m_up = 0; m_dn = 0; m_lead = 0; m_ev = 0; m_slip = 0; m_lossp = 0; loss_st = 0;
    endfunction

    function void clear_lock();
        g = 0;
        lock_edge = -1;
    endfunction

    function void measure(int v, bit lead);
        m_ev = 1; m_err = v; m_lead = lead;
        if (v <= TOL) begin
            if (g < LCNT) g++;
            if (g == LCNT && lock_edge < 0) lock_edge = e;
        end else begin
            clear_lock();
        end
    endfunction

    function void slip_ev();
        m_slip = 1; t_start = e; clear_lock();
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
        loss_st = 1;
`endif
    endfunction

    function void timeout_ev();
        pend = 0; clear_lock();
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
        loss_st = 1;
`else
        m_lossp = 1;
`endif
    endfunction

    // A level driven after edge n becomes a detected rise at edge n+3.
    function void model_step();
        bit rr, fr;
        m_ev = 0; m_slip = 0; m_lossp = 0;
        if (reset) begin
            model_reset();
            return;
        end
        rr = 0; fr = 0;
        if (e >= 4 && e - 3 < HN) begin
            rr = hist_ref[e-3] && !hist_ref[e-4];
            fr = hist_fb[e-3]  && !hist_fb[e-4];
        end
        if (pend == 0) begin
            if (rr && fr) measure(0, 0);
            else if (rr) begin pend = 1; t_start = e; end
            else if (fr) begin pend = 2; t_start = e; end
        end else if (pend == 1) begin
            if (fr) begin
                measure(e - t_start, 1);
                if (rr) t_start = e; else pend = 0;
            end else if (rr) slip_ev();
            else if (e - t_start == TOUT) timeout_ev();
        end else begin
            if (rr) begin
                measure(e - t_start, 0);
                if (fr) t_start = e; else pend = 0;
            end else if (fr) slip_ev();
            else if (e - t_start == TOUT) timeout_ev();
        end
        m_up = (pend == 1);
        m_dn = (pend == 2);
    endfunction

    // driver + model: model advances on each edge, inputs and reset change 1 time unit later
    initial begin
        pfd.refclk = 1'b0;
        pfd.fbclk  = 1'b0;
        model_reset();
        forever begin
            bit lr, lf;
            @(posedge clk);
            e++;
            model_step();
            #1;
            reset = rst_req;
            if (rst_req) begin
                lr = 0; lf = 0;
                model_reset();
            end else begin
                lr = lvl(ref_en, ref_t0, ref_per, e);
                lf = lvl(fb_en, fb_t0, fb_per, e);
            end
            pfd.refclk = lr;
            pfd.fbclk  = lf;
            if (e < HN) begin
                hist_ref[e] = lr;
                hist_fb[e]  = lf;
            end
        end
    end

    // compare process: every cycle against the model, plus event tracking
    initial forever begin
        bit exp_locked;
        @(negedge clk);
        if (e >= 1) begin
            exp_locked = (lock_edge >= 0) && (e > lock_edge) && !loss_st;
            chk("up",        pfd.up,            m_up);
            chk("dn",        pfd.dn,            m_dn);
            chk("err_valid", pfd.err_valid,     m_ev);
            chk("phase_err", int'(pfd.phase_err), m_err);
            chk("ref_leads", pfd.ref_leads,     m_lead);
            chk("slip",      pfd.slip,          m_slip);
            chk("loss",      pfd.loss,          m_lossp | loss_st);
            chk("locked",    pfd.locked,        exp_locked);
            if (pfd.err_valid) begin
                ev_n++;
                if (ev_n == 8) edge8 = e;
                if (exp_run > 0)
                    chk(pfd.ref_leads ? "up_run" : "dn_run",
                        pfd.ref_leads ? up_run : dn_run, exp_run);
                up_run = 0;
                dn_run = 0;
            end
            if (pfd.up) begin up_run++; up_tot++; if (up_first < 0) up_first = e; end
            if (pfd.dn) begin dn_run++; dn_tot++; end
            if (pfd.slip) slip_n++;
            if (pfd.loss) begin loss_n++; if (loss_first < 0) loss_first = e; end
            if (pfd.locked) begin locked_seen = 1; if (lock_first < 0) lock_first = e; end
        end
    end

    function void clr_track();
        ev_n = 0; edge8 = -1; up_run = 0; dn_run = 0; up_tot = 0; dn_tot = 0;
        up_first = -1; slip_n = 0; loss_n = 0; loss_first = -1; lock_first = -1;
        exp_run = 0; locked_seen = 0;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_req = 1; ref_en = 0; fb_en = 0;
        tick(3);
        rst_req = 0;
        tick(2);
        clr_track();
    endtask

    initial begin
        int k;
        clr_track();
        tick(4);
        // reset state
        chk("rst_up", pfd.up, 0);
        chk("rst_dn", pfd.dn, 0);
        chk("rst_err_valid", pfd.err_valid, 0);
        chk("rst_phase_err", int'(pfd.phase_err), 0);
        chk("rst_locked", pfd.locked, 0);
        chk("rst_loss", pfd.loss, 0);

        // aligned clocks, period 20: twelve zero-error measurements, lock after the 8th
        rst_req = 0; tick(2); clr_track();
        ref_per = 20; fb_per = 20; ref_t0 = e + 3; fb_t0 = e + 3; ref_en = 1; fb_en = 1;
        tick(235);
        chk("p1_ev_count", ev_n, 12);
        chk("p1_up_cycles", up_tot, 0);
        chk("p1_dn_cycles", dn_tot, 0);
        chk("p1_lock_latency", lock_first - edge8, 1);
        chk("p1_locked", pfd.locked, 1);

        // ref leads by 5
        do_reset();
        exp_run = 5;
        ref_t0 = e + 3; fb_t0 = e + 8; ref_en = 1; fb_en = 1;
        tick(125);
        chk("p2_ev_count", ev_n, 6);
        chk("p2_phase_err", int'(pfd.phase_err), 5);
        chk("p2_ref_leads", pfd.ref_leads, 1);
        chk("p2_locked_seen", locked_seen, 0);

        // fb leads by 2, then by 3
        do_reset();
        exp_run = 2;
        fb_t0 = e + 3; ref_t0 = e + 5; ref_en = 1; fb_en = 1;
        tick(240);
        chk("p3_ev_count", ev_n, 12);
        chk("p3_locked", pfd.locked, 1);
        chk("p3_ref_leads", pfd.ref_leads, 0);
        k = 0;
        while (((e - fb_t0) % 20) != 10 && k < 25) begin tick(1); k++; end
        fb_t0 = fb_t0 - 1;
        exp_run = 3;
        k = 0;
        tick(1);
        while (!pfd.err_valid && k < 30) begin tick(1); k++; end
        chk("p3_wait_ev", pfd.err_valid, 1);
        chk("p3_shift_err", int'(pfd.phase_err), 3);
        chk("p3_shift_locked", pfd.locked, 0);

        // frequency mismatch: slips
        do_reset();
        ref_per = 10; fb_per = 25; ref_t0 = e + 3; fb_t0 = e + 10; ref_en = 1; fb_en = 1;
        tick(200);
        chk("p4_slip_seen", slip_n > 0, 1);
        chk("p4_locked_seen", locked_seen, 0);

        // lock, then stop fbclk: timeout after 64 cycles in WAIT_FB
        do_reset();
        ref_per = 20; fb_per = 20; ref_t0 = e + 3; fb_t0 = e + 3; ref_en = 1; fb_en = 1;
        tick(200);
        chk("p5_locked_before", pfd.locked, 1);
        k = 0;
        while (((e - ref_t0) % 20) != 8 && k < 25) begin tick(1); k++; end
        fb_en = 0; ref_per = 200; ref_t0 = e + 5;
        clr_track();
        tick(140);
        chk("p5_timeout_delay", loss_first - up_first, TOUT);
        chk("p5_up", pfd.up, 0);
        chk("p5_locked", pfd.locked, 0);
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
        chk("p5_loss_held", pfd.loss, 1);
`else
        chk("p5_loss_count", loss_n, 1);
`endif
        ref_per = 20; ref_t0 = e + 3; fb_t0 = e + 3; fb_en = 1;
        tick(200);
`ifdef CYCLONEIIIGL_PFD_STICKY_LOSS_EN
        chk("p5_resume_locked", pfd.locked, 0);
        chk("p5_resume_loss", pfd.loss, 1);
`else
        chk("p5_resume_locked", pfd.locked, 1);
        chk("p5_resume_loss", pfd.loss, 0);
`endif

        // reset three cycles into WAIT_FB
        do_reset();
        ref_per = 20; fb_per = 20; ref_t0 = e + 3; ref_en = 1; fb_en = 0;
        k = 0;
        while (!pfd.up && k < 20) begin tick(1); k++; end
        chk("p6_wait_up", pfd.up, 1);
        tick(2);
        rst_req = 1; ref_en = 0;
        tick(1);
        chk("p6_up_in_reset", pfd.up, 0);
        chk("p6_ev_in_reset", pfd.err_valid, 0);
        chk("p6_loss_in_reset", pfd.loss, 0);
        tick(3);
        rst_req = 0;
        tick(2);
        clr_track();
        ref_t0 = e + 3; fb_t0 = e + 3; ref_en = 1; fb_en = 1;
        k = 0;
        while (!pfd.err_valid && k < 30) begin tick(1); k++; end
        chk("p6_wait_ev", pfd.err_valid, 1);
        chk("p6_phase_err", int'(pfd.phase_err), 0);
        chk("p6_ref_leads", pfd.ref_leads, 0);
        chk("p6_up_after", up_tot, 0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
